// File: rtl/record_tx_scheduler_if.sv
// rtl/record_tx_scheduler_if.sv - FIFO-side and serializer-side signals of the record transmit scheduler
interface record_tx_scheduler_if #(
    parameter int N_SRC      = 4,
    parameter int WORD_WIDTH = 144,
    parameter int SRC_W      = 2
);
    logic [N_SRC-1:0]            src_mask;
    logic [N_SRC-1:0]            src_empty;
    logic [N_SRC-1:0]            src_rdreq;
    logic [N_SRC*WORD_WIDTH-1:0] src_data;
    logic [WORD_WIDTH-1:0]       uart_data;
    logic [SRC_W-1:0]            uart_src;
    logic                        uart_send;
    logic                        uart_done;

    // Scheduler side
    modport master (
        input  src_mask, src_empty, src_data, uart_done,
        output src_rdreq, uart_data, uart_src, uart_send
    );

    // FIFO bank / serializer side
    modport slave (
        output src_mask, src_empty, src_data, uart_done,
        input  src_rdreq, uart_data, uart_src, uart_send
    );
endinterface

// File: rtl/record_tx_scheduler.sv
// rtl/record_tx_scheduler.sv - round-robin scheduler sharing one UART serializer across record FIFOs
module record_tx_scheduler #(
    parameter int N_SRC          = 4,
    parameter int WORD_WIDTH     = 144,
    parameter int SRC_W          = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    record_tx_scheduler_if.master bus,
    output logic                  busy,
    output logic [31:0]           words_sent,
    output logic                  timeout_err
);
    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(N_SRC - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        LATCH     = 3'd2,
        SEND      = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [SRC_W-1:0]     grant_q, grant_d;
    logic [SRC_W-1:0]     last_grant_q, last_grant_d;
    logic [CNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;

    logic [N_SRC-1:0]     rdreq_d;
    logic                 send_d;
    logic [WORD_WIDTH-1:0] data_d;
    logic [SRC_W-1:0]     src_d;
    logic [31:0]          sent_d;
    logic                 terr_d;
    logic                 busy_d;

    logic [N_SRC-1:0]     req;
    logic [SRC_W-1:0]     cand;
    logic [SRC_W-1:0]     pick;
    logic                 found;
    logic [WORD_WIDTH-1:0] sel_data;
    logic [CNT_W-1:0]     cnt_inc;

    // Next-state, round-robin pick and next values of every registered output
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tmo_cnt_d    = tmo_cnt_q;
        rdreq_d      = '0;
        send_d       = 1'b0;
        data_d       = bus.uart_data;
        src_d        = bus.uart_src;
        sent_d       = words_sent;
        terr_d       = timeout_err;
        busy_d       = 1'b0;

        // Search starts one past the previous grant so every busy source gets a turn
        req   = bus.src_mask & ~bus.src_empty;
        cand  = last_grant_q;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            cand = (cand == LAST_SRC) ? '0 : cand + SRC_W'(1);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        sel_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q == SRC_W'(i)) begin
                sel_data = bus.src_data[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end

        cnt_inc = tmo_cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (enable && found) begin
                    grant_d       = pick;
                    rdreq_d[pick] = 1'b1;
                    state_d       = READ;
                end
            end
            READ: begin
                // FIFO q becomes valid after the read pulse; capture it next cycle
                state_d = LATCH;
            end
            LATCH: begin
                data_d  = sel_data;
                src_d   = grant_q;
                send_d  = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                // A done level still high from the previous frame is ignored here
                tmo_cnt_d = '0;
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.uart_done) begin
                    sent_d       = words_sent + 32'd1;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else if (cnt_inc == TMO_LIMIT) begin
                    terr_d       = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else begin
                    tmo_cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and all outputs registered; reset aborts any word in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= LAST_SRC;
            tmo_cnt_q     <= '0;
            bus.src_rdreq <= '0;
            bus.uart_send <= 1'b0;
            bus.uart_data <= '0;
            bus.uart_src  <= '0;
            busy          <= 1'b0;
            words_sent    <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            tmo_cnt_q     <= tmo_cnt_d;
            bus.src_rdreq <= rdreq_d;
            bus.uart_send <= send_d;
            bus.uart_data <= data_d;
            bus.uart_src  <= src_d;
            busy          <= busy_d;
            words_sent    <= sent_d;
            timeout_err   <= terr_d;
        end
    end
endmodule
